instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and loader: the inverse of the main control unit's decode path. It accepts mnemonic-level instruction requests (operation code plus register/immediate/target fields) over a valid/ready handshake and encodes each into a 32-bit MIPS word. It buffers the words in a small FIFO and writes them sequentially into instruction memory through a write port with back-pressure. On request it terminates the program with the all-ones END word that the control unit decodes as program end.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000: byte address of first written word
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; in IDLE begins a session, loads address counter with BASE_ADDR
- finish  in  1  pulse; in RUN ends the session (drain, then append END)
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_mnem  in  5  operation code (table below)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- mem_we  out  1  write request
- mem_addr  out  32  byte address, advances by 4 per completed write
- mem_wdata  out  32  encoded word
- mem_ready  in  1  write completes on mem_we & mem_ready
- busy  out  1  state is RUN or DRAIN
- done  out  1  high in DONE
- err  out  1  sticky; set on unknown mnemonic, cleared only by start or rst
- word_count  out  16  words written this session, END included; saturates at 16'hFFFF

## Operation
- Mnemonic codes, with {op,funct} in hex:
  - 0 add {00,20}; 1 addu {00,21}; 2 sub {00,22}; 3 subu {00,23}
  - 4 and {00,24}; 5 nor {00,27}; 6 or {00,25}; 7 xor {00,26}
  - 8 srl {00,02}; 9 srlv {00,06}; 10 sll {00,00}; 11 sllv {00,04}
  - 12 sra {00,03}; 13 srav {00,07}; 14 slt {00,2A}; 15 jr {00,08}
  - 16 lw {23}; 17 sw {2B}; 18 addiu {09}; 19 addi {08}; 20 andi {0C}
  - 21 ori {0D}; 22 xori {0E}; 23 bne {05}; 24 beq {04}
  - 25 jal {03}; 26 j {02}; 27 end; 28 bubble
  - 29–31 unknown
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. For sll/srl/sra the rs field is forced to 0. For all other R-type the shamt field is forced to 0.
  - jr: {6'h00, rs, 15'b0, 6'h08}.
  - I-type: {op, rs, rt, imm}.
  - J-type: {op, target}.
  - end: 32'hFFFF_FFFF.
  - bubble: {26'b0, 6'h3F}.
- Unknown mnemonic: the request is accepted (handshake completes), no word is enqueued, and err is set.
- FSM states IDLE, RUN, DRAIN, DONE; reset state is IDLE.
  - IDLE: start → RUN. On entry, mem_addr=BASE_ADDR, word_count=0, err=0.
  - RUN: finish → DRAIN. If start is also high in the same cycle, it is ignored.
  - DRAIN: once the FIFO is empty, drive END. When the END write completes → DONE.
  - DONE: start → RUN, with the same reloads as leaving IDLE.
- A start pulse in RUN or DRAIN is ignored. A finish pulse outside RUN is ignored.
- FIFO accepts only in RUN. Requests are never accepted in DRAIN.
- Unsigned arithmetic throughout. mem_addr wraps modulo 2^32.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, word_count=0. The FIFO is emptied.
- Reset asserted mid-session aborts immediately: pending words are discarded and nothing further is written.
- in_ready = (state==RUN) & !full. This is combinational from registered state. There is no same-cycle bypass when full.
- Encoding is registered into the FIFO at accept. A request accepted at edge N can first appear on mem_we/mem_wdata in the cycle after edge N.
- mem_we=1 whenever the FIFO is non-empty in RUN or DRAIN, or during the END phase of DRAIN.
- mem_addr and mem_wdata hold stable while mem_we & !mem_ready.
- A completed write pops the FIFO and advances mem_addr by 4 and word_count by 1 at the same edge.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Sustained throughput is one word per cycle while mem_ready=1.
- done rises in the cycle after the END write completes and stays high until start.

## Test plan
- Basic encode: start; add rs=1 rt=2 rd=3 → mem_wdata=32'h0022_1820 @0x0; addi rs=1 rt=2 imm=16'hFFFF → 32'h2022_FFFF @0x4; finish → 32'hFFFF_FFFF @0x8; done=1, word_count=3.
- Field forcing: sll rs=7 rt=2 rd=3 shamt=4 → 32'h0002_1900 (rs forced to 0); j target=26'h10 → 32'h0800_0010; jr rs=31 → 32'h03E0_0008; bubble → 32'h0000_003F.
- Back-pressure: hold mem_ready=0 and push 5 requests with DEPTH=4 → 4 accepted, then in_ready=0; mem_addr and mem_wdata stable; release → 4 words written at consecutive addresses, then the 5th request is accepted.
- Unknown mnemonic 30 → accepted, err=1, no write; next valid request is written at the same mem_addr; start in DONE clears err.
- Reset mid-session: 3 words queued with mem_ready=0, then rst pulse → all outputs at reset values, FIFO empty, no further mem_we.
- Wrap: BASE_ADDR=32'hFFFF_FFF8; 3 words written → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: encodes mnemonic requests into MIPS words, buffers them
// in a FIFO and writes them to instruction memory, terminating with the END word.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, nextState;

    logic [31:0]    fifoMem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0] count;
    logic           fifoEmpty, fifoFull;
    logic           accept, push, pop, writeDone, startLoad;
    logic [31:0]    encWord, rWord, shWord, iBase, jBase;
    logic           encKnown;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == (PTR_W+1)'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign push      = accept & encKnown;
    assign writeDone = mem_we & mem_ready;
    assign pop       = writeDone & !fifoEmpty;
    assign startLoad = start & ((state == S_IDLE) | (state == S_DONE));

    // Field templates; the op/funct codes are OR-ed in by the decode below
    assign rWord  = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h00};
    assign shWord = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
    assign iBase  = {6'h00, in_rs, in_rt, in_imm};
    assign jBase  = {6'h00, in_target};

    always_comb begin
        encWord  = 32'h0;
        encKnown = 1'b1;
        case (in_mnem)
            5'd0:  encWord = rWord  | 32'h20;
            5'd1:  encWord = rWord  | 32'h21;
            5'd2:  encWord = rWord  | 32'h22;
            5'd3:  encWord = rWord  | 32'h23;
            5'd4:  encWord = rWord  | 32'h24;
            5'd5:  encWord = rWord  | 32'h27;
            5'd6:  encWord = rWord  | 32'h25;
            5'd7:  encWord = rWord  | 32'h26;
            5'd8:  encWord = shWord | 32'h02;
            5'd9:  encWord = rWord  | 32'h06;
            5'd10: encWord = shWord | 32'h00;
            5'd11: encWord = rWord  | 32'h04;
            5'd12: encWord = shWord | 32'h03;
            5'd13: encWord = rWord  | 32'h07;
            5'd14: encWord = rWord  | 32'h2A;
            5'd15: encWord = {6'h00, in_rs, 15'd0, 6'h08};
            5'd16: encWord = iBase  | {6'h23, 26'd0};
            5'd17: encWord = iBase  | {6'h2B, 26'd0};
            5'd18: encWord = iBase  | {6'h09, 26'd0};
            5'd19: encWord = iBase  | {6'h08, 26'd0};
            5'd20: encWord = iBase  | {6'h0C, 26'd0};
            5'd21: encWord = iBase  | {6'h0D, 26'd0};
            5'd22: encWord = iBase  | {6'h0E, 26'd0};
            5'd23: encWord = iBase  | {6'h05, 26'd0};
            5'd24: encWord = iBase  | {6'h04, 26'd0};
            5'd25: encWord = jBase  | {6'h03, 26'd0};
            5'd26: encWord = jBase  | {6'h02, 26'd0};
            5'd27: encWord = END_WORD;
            5'd28: encWord = 32'h0000_003F;
            default: encKnown = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (start) nextState = S_RUN;
            S_RUN:   if (finish) nextState = S_DRAIN;
            S_DRAIN: if (fifoEmpty && mem_ready) nextState = S_DONE;
            S_DONE:  if (start) nextState = S_RUN;
            default: nextState = S_IDLE;
        endcase
    end

    // In DRAIN with an empty FIFO the END word is presented
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                in_ready = !fifoFull;
                mem_we   = !fifoEmpty;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        if (!fifoEmpty)             mem_wdata = fifoMem[rdPtr];
        else if (state == S_DRAIN)  mem_wdata = END_WORD;
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= encWord;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= BASE_ADDR;
            word_count <= 16'h0;
            err        <= 1'b0;
        end else if (startLoad) begin
            mem_addr   <= BASE_ADDR;
            word_count <= 16'h0;
            err        <= 1'b0;
        end else begin
            if (writeDone) mem_addr <= mem_addr + 32'd4;
            if (writeDone && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            if (accept && !encKnown) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a scoreboard of expected writes, checked on two
// instances (base 0 and a base near the top of the address space).
module tb_instr_encoder;
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, start, finish, in_valid, mem_ready;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;
    logic        inReady2, memWe2, busy2, done2, err2;
    logic [31:0] memAddr2, memWdata2;
    logic [15:0] wordCount2;

    typedef struct {
        logic [31:0] off;
        logic [31:0] data;
    } exp_t;
    exp_t        sbQ[$];
    logic [31:0] expOff;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err), .word_count(word_count));

    instr_encoder #(.DEPTH(4), .BASE_ADDR(WRAP_BASE)) dutWrap (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(inReady2), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .mem_we(memWe2), .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_ready(mem_ready),
        .busy(busy2), .done(done2), .err(err2), .word_count(wordCount2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every completed write is matched against the oldest expected word
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            check("we_match", {31'b0, memWe2}, 32'd1);
            if (sbQ.size() == 0) begin
                check("spurious_write", {31'b0, mem_we}, 32'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                check("wdata", mem_wdata, e.data);
                check("addr", mem_addr, e.off);
                check("wdata_wrap", memWdata2, e.data);
                check("addr_wrap", memAddr2, e.off + WRAP_BASE);
            end
        end
    end

    task automatic expectWord(input logic [31:0] data);
        sbQ.push_back('{off: expOff, data: data});
        expOff = expOff + 32'd4;
    endtask

    task automatic driveReq(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                            input logic [25:0] tgt);
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_valid = 1'b1;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] expData, input logic known);
        @(posedge clk); #1;
        driveReq(m, rs, rt, rd, sh, imm, tgt);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        if (known) expectWord(expData);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic doStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        expOff = 32'h0;
    endtask

    task automatic doFinish();
        expectWord(32'hFFFF_FFFF);
        @(posedge clk); #1 finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0;
    endtask

    task automatic waitDone(input logic [15:0] expCount);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", {31'b0, done}, 32'd1);
        check("word_count", {16'b0, word_count}, {16'b0, expCount});
        check("queue_drained", sbQ.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        driveReq(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b0;
        expOff = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_addr_wrap", memAddr2, WRAP_BASE);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
        check("rst_word_count", {16'b0, word_count}, 32'd0);

        // Basic encode
        doStart();
        @(negedge clk);
        check("busy_run", {31'b0, busy}, 32'd1);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
        send(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h2022_FFFF, 1'b1);
        doFinish();
        waitDone(16'd3);

        // Back-pressure with field-forcing patterns
        mem_ready = 1'b0;
        doStart();
        send(5'd10, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 32'h0002_1900, 1'b1);
        send(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h0800_0010, 1'b1);
        send(5'd15, 5'd31, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 32'h03E0_0008, 1'b1);
        send(5'd28, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0000_003F, 1'b1);
        @(posedge clk); #1;
        driveReq(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_we", {31'b0, mem_we}, 32'd1);
            check("stall_addr", mem_addr, 32'h0);
            check("stall_wdata", mem_wdata, 32'h0002_1900);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_fifth", {31'b0, in_ready}, 32'd1);
        expectWord(32'h0022_1820);
        @(posedge clk); #1 in_valid = 1'b0;
        doFinish();
        waitDone(16'd6);

        // Unknown mnemonic, sticky err, more encodings
        doStart();
        send(5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("err_set", {31'b0, err}, 32'd1);
        check("unknown_no_we", {31'b0, mem_we}, 32'd0);
        send(5'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h0085_3020, 1'b1);
        send(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h8FA8_0010, 1'b1);
        send(5'd13, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 32'h0022_1807, 1'b1);
        doFinish();
        waitDone(16'd4);
        check("err_sticky", {31'b0, err}, 32'd1);
        doStart();
        @(negedge clk);
        check("err_cleared", {31'b0, err}, 32'd0);
        check("done_cleared", {31'b0, done}, 32'd0);
        doFinish();
        waitDone(16'd1);

        // Reset mid-session
        mem_ready = 1'b0;
        doStart();
        send(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1825, 1'b1);
        send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821, 1'b1);
        send(5'd21, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3422_1234, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        #2;
        sbQ.delete();
        check("mid_rst_we", {31'b0, mem_we}, 32'd0);
        check("mid_rst_flags", {28'b0, in_ready, busy, done, err}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_wdata", mem_wdata, 32'h0);
        check("mid_rst_count", {16'b0, word_count}, 32'd0);
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
        doStart();
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_we", {31'b0, mem_we}, 32'd0);
        end
        doFinish();
        waitDone(16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
